// File: rtl/keynsham_timer.sv
// Down-counting bus timer with one-shot/periodic modes, sticky expiry flag and level irq.
// Optional prescaler (PRESCALE register at offset 4) enabled by defining KEYNSHAM_TIMER_PRESCALER_EN.
module keynsham_timer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        bus_access,
    input  logic        bus_cs,
    input  logic [29:0] bus_addr,
    input  logic [31:0] bus_wr_val,
    input  logic        bus_wr_en,
    input  logic [3:0]  bus_bytesel,
    output logic        bus_ack,
    output logic        bus_error,
    output logic [31:0] bus_data,
    output logic        irq
);

    typedef enum logic [2:0] {
        REG_COUNT    = 3'd0,
        REG_RELOAD   = 3'd1,
        REG_CTRL     = 3'd2,
        REG_STATUS   = 3'd3,
        REG_PRESCALE = 3'd4
    } reg_offset_e;

    logic [CNT_WIDTH-1:0] count;
    logic [CNT_WIDTH-1:0] reload;
    logic                 ctrl_enable;
    logic                 ctrl_periodic;
    logic                 ctrl_irq_en;
    logic                 expired;

    logic        access;
    logic [2:0]  offset;
    logic        offset_ok;
    logic        wr;
    logic        wr_count;
    logic        wr_reload;
    logic        wr_ctrl;
    logic        wr_status;
    logic        tick;
    logic        expire;
    logic        enable_rise;
    logic [2:0]  ctrl_next;
    logic [31:0] count_ext;
    logic [31:0] reload_ext;
    logic [31:0] count_merged;
    logic [31:0] reload_merged;
    logic [31:0] rd_data;
    logic        unused_bits;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

    assign access    = bus_access & bus_cs;
    assign offset    = bus_addr[2:0];
    assign wr        = access & bus_wr_en & offset_ok;
    assign wr_count  = wr && (offset == REG_COUNT);
    assign wr_reload = wr && (offset == REG_RELOAD);
    assign wr_ctrl   = wr && (offset == REG_CTRL);
    assign wr_status = wr && (offset == REG_STATUS);

    always_comb begin
        count_ext  = '0;
        reload_ext = '0;
        count_ext[CNT_WIDTH-1:0]  = count;
        reload_ext[CNT_WIDTH-1:0] = reload;
    end

    assign count_merged  = merge_bytes(count_ext, bus_wr_val, bus_bytesel);
    assign reload_merged = merge_bytes(reload_ext, bus_wr_val, bus_bytesel);
    assign ctrl_next     = bus_bytesel[0] ? bus_wr_val[2:0]
                                          : {ctrl_irq_en, ctrl_periodic, ctrl_enable};
    assign enable_rise   = wr_ctrl && ctrl_next[0] && !ctrl_enable;
    assign expire        = tick && (count == '0);
    assign irq           = expired & ctrl_irq_en;
    assign unused_bits   = ^{bus_addr[29:3], count_merged, reload_merged};

`ifdef KEYNSHAM_TIMER_PRESCALER_EN
    logic [15:0] prescale;
    logic [15:0] divider;
    logic        wr_prescale;

    assign offset_ok   = (offset <= REG_PRESCALE);
    assign wr_prescale = wr && (offset == REG_PRESCALE);
    assign tick        = ctrl_enable && (divider == prescale);

    // Divider restarts on enable and on PRESCALE write so the first tick is a full period away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prescale <= '0;
            divider  <= '0;
        end else begin
            if (wr_prescale) begin
                prescale <= {bus_bytesel[1] ? bus_wr_val[15:8] : prescale[15:8],
                             bus_bytesel[0] ? bus_wr_val[7:0]  : prescale[7:0]};
            end
            if (enable_rise || wr_prescale) begin
                divider <= '0;
            end else if (ctrl_enable) begin
                divider <= (divider == prescale) ? 16'd0 : divider + 16'd1;
            end
        end
    end
`else
    assign offset_ok = (offset <= REG_STATUS);
    assign tick      = ctrl_enable;
`endif

    always_comb begin
        rd_data = '0;
        case (offset)
            REG_COUNT:    rd_data = count_ext;
            REG_RELOAD:   rd_data = reload_ext;
            REG_CTRL:     rd_data = {29'd0, ctrl_irq_en, ctrl_periodic, ctrl_enable};
            REG_STATUS:   rd_data = {31'd0, expired};
`ifdef KEYNSHAM_TIMER_PRESCALER_EN
            REG_PRESCALE: rd_data = {16'd0, prescale};
`endif
            default:      rd_data = '0;
        endcase
    end

    // Software writes win over hardware updates, except expiry which beats a W1C clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count         <= '0;
            reload        <= '0;
            ctrl_enable   <= 1'b0;
            ctrl_periodic <= 1'b0;
            ctrl_irq_en   <= 1'b0;
            expired       <= 1'b0;
        end else begin
            if (enable_rise) begin
                count <= reload;
            end else if (wr_count) begin
                count <= count_merged[CNT_WIDTH-1:0];
            end else if (tick) begin
                if (count != '0)        count <= count - CNT_WIDTH'(1);
                else if (ctrl_periodic) count <= reload;
            end

            if (wr_reload) reload <= reload_merged[CNT_WIDTH-1:0];

            if (wr_ctrl) begin
                {ctrl_irq_en, ctrl_periodic, ctrl_enable} <= ctrl_next;
            end else if (expire && !ctrl_periodic) begin
                ctrl_enable <= 1'b0;
            end

            if (expire) begin
                expired <= 1'b1;
            end else if (wr_status && bus_bytesel[0] && bus_wr_val[0]) begin
                expired <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus_ack   <= 1'b0;
            bus_error <= 1'b0;
            bus_data  <= '0;
        end else begin
            bus_ack   <= access;
            bus_error <= access & ~offset_ok;
            bus_data  <= (access && !bus_wr_en && offset_ok) ? rd_data : 32'd0;
        end
    end

endmodule
